rr_mux_scheduler: RTL and testbench
===================================

# rr_mux_scheduler

Four-channel, round-robin scheduler that feeds the 32-bit four-input select mux (`bit32_2to1mux`) and consumes its output. Each channel deposits one word into a holding register. The block arbitrates among full channels and drives the mux select pair and data inputs. It captures the selected word into an output register with a valid/ready handshake and tags it with the source channel.

## Interface

Parameters:
- `WIDTH`, default 32: data word width. Must match the mux width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_data0`..`in_data3`, input, `WIDTH` each: channel write data.
- `in_valid`, input, 4: per-channel write request.
- `in_ready`, output, 4: per-channel holding register empty.
- `mux_in1`..`mux_in4`, output, `WIDTH` each: holding registers 0..3, driven straight to the mux data inputs.
- `mux_sel1`, output, 1: select LSB to the mux.
- `mux_sel2`, output, 1: select MSB to the mux.
- `mux_out`, input, `WIDTH`: combinational result returned by the mux.
- `out_data`, output, `WIDTH`: captured word.
- `out_chan`, output, 2: source channel of `out_data`.
- `out_valid`, output, 1: output register holds a word.
- `out_ready`, input, 1: downstream accepts the word.

## Operation

Channel mapping:
- Channel i maps to {`mux_sel2`,`mux_sel1`} = i: 00→in1, 01→in2, 10→in3, 11→in4.
- `mux_sel1` is bit 0 of i; `mux_sel2` is bit 1.

Holding registers:
- `full[i]` is set when `in_valid[i] && in_ready[i]`; `in_data_i` is loaded on that edge.
- `in_ready[i] = !full[i]`, combinational.
- A channel is never loaded and cleared on the same edge, because `in_ready` is low while full.

Round-robin pointer `ptr` (2 bits):
- The winner is the first full channel found searching ptr, ptr+1, ptr+2, ptr+3, with mod-4 wrap-around.
- After a capture, `ptr` = winner+1 mod 4. Channel 3 wraps to 0.

FSM states:
- **IDLE**: if any `full`, register the winner into `mux_sel2`/`mux_sel1` and `grant_ch`, then go to GRANT. Otherwise stay in IDLE; the selects hold their last value.
- **GRANT**: the selects are stable for this whole cycle. At the end of the cycle:
  - `out_data <= mux_out`, `out_chan <= grant_ch`, `out_valid <= 1`.
  - clear `full[grant_ch]`, update `ptr`.
  - go to OUT.
- **OUT**: hold `out_data` and `out_chan` stable while `out_valid && !out_ready`. When `out_ready` is high, `out_valid <= 0` on that edge and go to IDLE.

Other rules:
- A channel loaded while another is being served joins the next arbitration.
- The winner is fixed at the IDLE→GRANT edge. Later loads do not preempt it.

Reset (`rst_n` low at an edge), including mid-operation:
- state IDLE, `full` = 0000, `ptr` = 0, selects = 00, `grant_ch` = 0.
- `out_valid` = 0, `out_data` = 0, `out_chan` = 0.
- holding registers = 0, so `in_ready` = 1111 after reset.
- Any word in flight is discarded.

## Timing

- Load edge E0 → IDLE sees `full` in cycle E0..E1 → selects registered at E1 → capture at E2. `out_valid` is high after E2: 2-cycle latency.
- Minimum 3 cycles per word: IDLE, GRANT, OUT with `out_ready` held high.
- The mux path is combinational, `mux_in*`/selects → `mux_out`. It must settle within one cycle.
- Selects and `mux_in[grant_ch]` must not change during GRANT. This is guaranteed because `in_ready[grant_ch]` is 0.
- `in_ready` deasserts the cycle after the load edge. It reasserts the cycle after the capture edge.

## Structure

Shared package (`rr_mux_pkg`):
- `WIDTH_DEFAULT = 32`.
- state encoding `ST_IDLE = 2'd0`, `ST_GRANT = 2'd1`, `ST_OUT = 2'd2`.
- channel-index width `CH_W = 2`.

Sub-module:
- `rr_pick4`: combinational round-robin picker. Inputs are `full[3:0]` and `ptr[1:0]`; outputs are `winner[1:0]` and `any`.

The mux itself stays external and is instantiated beside this block at top level.

## Test plan

- **Reset**: hold `rst_n` = 0 for 2 cycles, then release.
  - Expect `in_ready` = 1111, `out_valid` = 0, selects = 00, `out_data` = 0.
- **Single word**: load ch2 with 32'h0000_1240 at E0, `out_ready` = 1.
  - Expect selects = 10 from E1, `out_data` = 32'h0000_1240 and `out_chan` = 2 with `out_valid` high after E2, `in_ready[2]` = 1 after E2.
- **All four channels**: load ch0 = AAAA_AAAA, ch1 = 5555_5555, ch2 = 0000_1240, ch3 = 0 on the same edge, `ptr` = 0.
  - Expect outputs in channel order 0, 1, 2, 3, each 3 cycles apart.
- **Wrap-around**: with `ptr` = 3 after serving ch2, load ch0 and ch3 together.
  - Expect ch3 served first, then ch0.
- **Back-pressure**: hold `out_ready` = 0 for 5 cycles with the output register full.
  - Expect `out_data`/`out_chan` stable and `out_valid` = 1 throughout.
  - Expect selects unchanged and no `full` bit cleared.
- **Reset mid-operation**: assert `rst_n` = 0 during GRANT with ch1 full.
  - Expect no output, `full` = 0000, `in_ready` = 1111 the next cycle.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux scheduler: widths, FSM encoding
// and the channel-index wrap helper.
package rr_mux_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CH_W          = 2;
    localparam int N_CH          = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Channel after ch, wrapping 3 -> 0 through the natural 2-bit overflow.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return ch + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first full channel at or after ptr,
// searching with mod-4 wrap-around.
module rr_pick4
    import rr_mux_pkg::*;
(
    input  logic [N_CH-1:0] full,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] winner,
    output logic            any
);

    logic [CH_W-1:0] w_idx;

    // Scan from the farthest offset down so the closest full channel wins last.
    always_comb begin
        winner = 2'd0;
        any    = 1'b0;
        w_idx  = 2'd0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx  = ptr + CH_W'(k);
            winner = full[w_idx] ? w_idx : winner;
            any    = any | full[w_idx];
        end
    end

endmodule

// File: rtl/rr_mux_scheduler.sv
// Four-channel round-robin scheduler driving an external 4-input select mux
// and capturing its result into a valid/ready output register.
module rr_mux_scheduler
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] mux_in1,
    output logic [WIDTH-1:0] mux_in2,
    output logic [WIDTH-1:0] mux_in3,
    output logic [WIDTH-1:0] mux_in4,
    output logic             mux_sel1,
    output logic             mux_sel2,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N_CH-1:0] r_full;
    logic [WIDTH-1:0] r_hold [N_CH];
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] r_sel;
    logic [CH_W-1:0] r_grant_ch;
    logic [WIDTH-1:0] r_out_data;
    logic [CH_W-1:0] r_out_chan;
    logic            r_out_valid;

    logic [WIDTH-1:0] w_in_data [N_CH];
    logic [N_CH-1:0]  w_load;
    logic [CH_W-1:0]  w_winner;
    logic             w_any;
    logic             w_grant_start;
    logic             w_capture;
    logic             w_release;

    assign w_in_data[0] = in_data0;
    assign w_in_data[1] = in_data1;
    assign w_in_data[2] = in_data2;
    assign w_in_data[3] = in_data3;

    assign w_load        = in_valid & ~r_full;
    assign w_grant_start = (r_state == ST_IDLE) && w_any;
    assign w_capture     = (r_state == ST_GRANT);
    assign w_release     = (r_state == ST_OUT) && out_ready;

    rr_pick4 u_pick (
        .full   (r_full),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_any ? ST_GRANT : ST_IDLE;
            ST_GRANT: w_state_nxt = ST_OUT;
            ST_OUT:   w_state_nxt = out_ready ? ST_IDLE : ST_OUT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding registers: load when empty, free the granted channel on capture.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (!rst_n) begin
                r_full[i] <= 1'b0;
                r_hold[i] <= {WIDTH{1'b0}};
            end else if (w_load[i]) begin
                r_full[i] <= 1'b1;
                r_hold[i] <= w_in_data[i];
            end else if (w_capture && (r_grant_ch == CH_W'(i))) begin
                r_full[i] <= 1'b0;
            end else begin
                r_full[i] <= r_full[i];
            end
        end
    end

    // Winner latch and pointer; the selects stay put until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel      <= 2'd0;
            r_grant_ch <= 2'd0;
            r_ptr      <= 2'd0;
        end else if (w_grant_start) begin
            r_sel      <= w_winner;
            r_grant_ch <= w_winner;
        end else if (w_capture) begin
            r_ptr      <= next_ch(r_grant_ch);
        end else begin
            r_sel      <= r_sel;
        end
    end

    // Output register with valid/ready hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= {WIDTH{1'b0}};
            r_out_chan  <= 2'd0;
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_data  <= mux_out;
            r_out_chan  <= r_grant_ch;
            r_out_valid <= 1'b1;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready  = ~r_full;
    assign mux_in1   = r_hold[0];
    assign mux_in2   = r_hold[1];
    assign mux_in3   = r_hold[2];
    assign mux_in4   = r_hold[3];
    assign mux_sel1  = r_sel[0];
    assign mux_sel2  = r_sel[1];
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a transaction-level model of the scheduler and the external mux.
module tb_rr_mux_scheduler;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data [4];
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] mux_in1, mux_in2, mux_in3, mux_in4;
    logic         mux_sel1, mux_sel2;
    logic [W-1:0] mux_out;
    logic [W-1:0] out_data;
    logic [1:0]   out_chan;
    logic         out_valid;
    logic         out_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: pending words, RR pointer and service phase
    // (0 free, 1 granted, 2 word presented downstream).
    bit           m_pend [4];
    logic [W-1:0] m_data [4];
    int           m_ptr, m_phase, m_gch, m_sel, m_oc;
    bit           m_ov;
    logic [W-1:0] m_od;

    always #5 clk = ~clk;

    // External 4-input select mux beside the scheduler.
    assign mux_out = mux_sel2 ? (mux_sel1 ? mux_in4 : mux_in3)
                              : (mux_sel1 ? mux_in2 : mux_in1);

    rr_mux_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data0(in_data[0]), .in_data1(in_data[1]),
        .in_data2(in_data[2]), .in_data3(in_data[3]),
        .in_valid(in_valid), .in_ready(in_ready),
        .mux_in1(mux_in1), .mux_in2(mux_in2), .mux_in3(mux_in3), .mux_in4(mux_in4),
        .mux_sel1(mux_sel1), .mux_sel2(mux_sel2), .mux_out(mux_out),
        .out_data(out_data), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic logic [3:0] m_ready();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = !m_pend[i];
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit op [4];
        op = m_pend;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 1'b0;
                m_data[i] = '0;
            end
            m_ptr = 0; m_phase = 0; m_gch = 0; m_sel = 0;
            m_ov = 1'b0; m_od = '0; m_oc = 0;
        end else begin
            if (m_phase == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_phase == 0 && op[(m_ptr + k) % 4]) begin
                        m_gch = (m_ptr + k) % 4;
                        m_sel = m_gch;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_od = m_data[m_gch];
                m_oc = m_gch;
                m_ov = 1'b1;
                m_pend[m_gch] = 1'b0;
                m_ptr = (m_gch + 1) % 4;
                m_phase = 2;
            end else if (out_ready) begin
                m_ov = 1'b0;
                m_phase = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && !op[i]) begin
                    m_pend[i] = 1'b1;
                    m_data[i] = in_data[i];
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_out(input int limit, output bit ok);
        int n = 0;
        while (!out_valid && n < limit) begin
            tick();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'h0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i] = '0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready got %h exp f", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({mux_sel2, mux_sel1} !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", {mux_sel2, mux_sel1}); end
        checks++; if (out_data !== 32'h0 || out_chan !== 2'd0) begin errors++; $display("FAIL reset_out got %h/%0d exp 0/0", out_data, out_chan); end
    endtask

    task automatic test_all_four();
        logic [W-1:0] exp [4];
        bit ok;
        int c0;
        exp[0] = 32'hAAAA_AAAA; exp[1] = 32'h5555_5555; exp[2] = 32'h0000_1240; exp[3] = 32'h0;
        for (int i = 0; i < 4; i++) in_data[i] = exp[i];
        in_valid = 4'hF; out_ready = 1'b1;
        tick();
        in_valid = 4'h0;
        c0 = cyc;
        checks++; if (in_ready !== 4'h0) begin errors++; $display("FAIL all4_in_ready got %h exp 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            wait_out(8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL all4_timeout word %0d got no out_valid exp 1", k); end
            checks++; if (out_chan !== 2'(k) || out_data !== exp[k]) begin errors++; $display("FAIL all4_word got ch%0d %h exp ch%0d %h", out_chan, out_data, k, exp[k]); end
            checks++; if (cyc - c0 !== 2 + 3 * k) begin errors++; $display("FAIL all4_latency got %0d exp %0d", cyc - c0, 2 + 3 * k); end
            tick();
        end
    endtask

    task automatic test_single_word();
        in_data[2] = 32'h0000_1240; in_valid = 4'b0100; out_ready = 1'b1;
        tick();
        in_valid = 4'h0;
        checks++; if (in_ready !== 4'b1011 || out_valid !== 1'b0) begin errors++; $display("FAIL single_e0 got rdy %b ov %b exp 1011 0", in_ready, out_valid); end
        tick();
        checks++; if ({mux_sel2, mux_sel1} !== 2'b10 || out_valid !== 1'b0) begin errors++; $display("FAIL single_e1 got sel %b ov %b exp 10 0", {mux_sel2, mux_sel1}, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1240 || out_chan !== 2'd2) begin errors++; $display("FAIL single_e2 got %b %h %0d exp 1 00001240 2", out_valid, out_data, out_chan); end
        checks++; if (in_ready !== 4'hF) begin errors++; $display("FAIL single_ready got %b exp 1111", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_release got %b exp 0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] d0, d3;
        bit ok;
        d0 = $urandom; d3 = $urandom;
        in_data[0] = d0; in_data[3] = d3; in_valid = 4'b1001; out_ready = 1'b1;
        tick();
        in_valid = 4'h0;
        wait_out(8, ok);
        checks++; if (!ok || out_chan !== 2'd3 || out_data !== d3) begin errors++; $display("FAIL wrap_first got ch%0d %h exp ch3 %h", out_chan, out_data, d3); end
        tick();
        wait_out(8, ok);
        checks++; if (!ok || out_chan !== 2'd0 || out_data !== d0) begin errors++; $display("FAIL wrap_second got ch%0d %h exp ch0 %h", out_chan, out_data, d0); end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] d1, d0;
        bit ok;
        d1 = $urandom; d0 = $urandom;
        in_data[1] = d1; in_valid = 4'b0010; out_ready = 1'b0;
        tick();
        in_valid = 4'h0;
        wait_out(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no out_valid exp 1"); end
        in_data[0] = d0; in_valid = 4'b0001;
        tick();
        in_valid = 4'h0;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== d1 || out_chan !== 2'd1 ||
                {mux_sel2, mux_sel1} !== 2'b01 || in_ready !== 4'b1110) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got ov %b %h ch%0d sel %b rdy %b exp 1 %h ch1 01 1110",
                         n, out_valid, out_data, out_chan, {mux_sel2, mux_sel1}, in_ready, d1);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", out_valid); end
        wait_out(8, ok);
        checks++; if (!ok || out_chan !== 2'd0 || out_data !== d0) begin errors++; $display("FAIL bp_next got ch%0d %h exp ch0 %h", out_chan, out_data, d0); end
        tick();
    endtask

    task automatic test_reset_mid();
        in_data[1] = $urandom; in_valid = 4'b0010; out_ready = 1'b1;
        tick();
        in_valid = 4'h0;
        tick();
        checks++; if ({mux_sel2, mux_sel1} !== 2'b01) begin errors++; $display("FAIL rmid_grant got sel %b exp 01", {mux_sel2, mux_sel1}); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 4'hF || {mux_sel2, mux_sel1} !== 2'b00 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL rmid_state got ov %b rdy %b sel %b %h exp 0 1111 00 0",
                     out_valid, in_ready, {mux_sel2, mux_sel1}, out_data);
        end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_output cycle %0d got %b exp 0", n, out_valid); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) in_data[i] = $urandom;
            tick();
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", cyc, in_ready, m_ready()); end
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", cyc, out_valid, m_ov); end
            checks++; if ({mux_sel2, mux_sel1} !== 2'(m_sel)) begin errors++; $display("FAIL rnd_sel cyc %0d got %b exp %0d", cyc, {mux_sel2, mux_sel1}, m_sel); end
            checks++; if (out_data !== m_od || out_chan !== 2'(m_oc)) begin errors++; $display("FAIL rnd_out cyc %0d got %h ch%0d exp %h ch%0d", cyc, out_data, out_chan, m_od, m_oc); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_all_four();
        test_single_word();
        test_wrap();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
